// File: rtl/dom1_sbox_layer_seq.sv
// rtl/dom1_sbox_layer_seq.sv - byte-serial two-share driver for a first-order DOM 8-bit S-box
//
// Optional build macro: DOM1_SEQ_INT_PRNG_EN
//   defined   : S-box randomness comes from an internal 32-bit Galois LFSR; rnd_in/rnd_valid unused, rnd_ready tied 0
//   undefined : S-box randomness comes from the rnd_in/rnd_valid/rnd_ready handshake
module dom1_sbox_layer_seq #(
    parameter int SBOX_LAT = 3,
    parameter int NBYTES   = 16
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  start,
    input  logic [8*NBYTES-1:0]   state_in_s0,
    input  logic [8*NBYTES-1:0]   state_in_s1,
    input  logic [7:0]            rnd_in,
    input  logic                  rnd_valid,
    output logic                  rnd_ready,
    output logic [7:0]            sb_x0,
    output logic [7:0]            sb_x1,
    output logic [7:0]            sb_r,
    input  logic [7:0]            sb_y0,
    input  logic [7:0]            sb_y1,
    output logic [8*NBYTES-1:0]   state_out_s0,
    output logic [8*NBYTES-1:0]   state_out_s1,
    output logic                  busy,
    output logic                  done
);

    localparam int SW = 8 * NBYTES;
    localparam int BW = (NBYTES > 1) ? $clog2(NBYTES) : 1;
    localparam int HW = (SBOX_LAT > 0) ? $clog2(SBOX_LAT + 1) : 1;

    localparam logic [BW-1:0] LAST_BYTE = BW'(NBYTES - 1);
    localparam logic [HW-1:0] HOLD_LAST = HW'(SBOX_LAT);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_FETCH = 2'd1,
        S_HOLD  = 2'd2,
        S_DONE  = 2'd3
    } state_t;

    state_t          fsm;
    logic [SW-1:0]   sh_s0;
    logic [SW-1:0]   sh_s1;
    logic [BW-1:0]   byte_cnt;
    logic [HW-1:0]   hold_cnt;
    logic            ready_q;

    // Each share shifts independently; the settled S-box byte enters at the top
    // so after NBYTES captures byte k is back at bits [8k+7:8k].
    logic [SW-1:0]   nxt_s0;
    logic [SW-1:0]   nxt_s1;
    assign nxt_s0 = {sb_y0, sh_s0[SW-1:8]};
    assign nxt_s1 = {sb_y1, sh_s1[SW-1:8]};

    // Randomness source selection: fetch_xfer marks the cycle a byte is issued.
    logic            fetch_xfer;
    logic [7:0]      rnd_src;
    logic            ready_en;

`ifdef DOM1_SEQ_INT_PRNG_EN
    logic [31:0]     lfsr;
    logic            unused_rnd;

    assign unused_rnd = ^{rnd_in, rnd_valid};
    assign ready_en   = 1'b0;
    assign fetch_xfer = (fsm == S_FETCH);
    assign rnd_src    = lfsr[7:0];

    // Galois LFSR x^32+x^22+x^2+x+1: seeded at start (zero seed forced to 1), steps once per issued byte.
    always_ff @(posedge clk) begin
        if (rst) begin
            lfsr <= 32'h0;
        end else if (fsm == S_IDLE && start) begin
            lfsr <= (state_in_s1[31:0] == 32'h0) ? 32'h1 : state_in_s1[31:0];
        end else if (fsm == S_FETCH) begin
            lfsr <= (lfsr >> 1) ^ (lfsr[0] ? 32'h8020_0003 : 32'h0);
        end
    end
`else
    assign ready_en   = 1'b1;
    assign fetch_xfer = ready_q & rnd_valid;
    assign rnd_src    = rnd_in;
`endif

    assign rnd_ready = ready_q;

    // Layer sequencer: fetch randomness, hold the byte for the S-box depth, capture, repeat.
    always_ff @(posedge clk) begin
        if (rst) begin
            fsm          <= S_IDLE;
            sh_s0        <= '0;
            sh_s1        <= '0;
            byte_cnt     <= '0;
            hold_cnt     <= '0;
            ready_q      <= 1'b0;
            sb_x0        <= 8'h00;
            sb_x1        <= 8'h00;
            sb_r         <= 8'h00;
            state_out_s0 <= '0;
            state_out_s1 <= '0;
            busy         <= 1'b0;
            done         <= 1'b0;
        end else begin
            done <= 1'b0;
            case (fsm)
                S_IDLE: begin
                    if (start) begin
                        sh_s0    <= state_in_s0;
                        sh_s1    <= state_in_s1;
                        byte_cnt <= '0;
                        busy     <= 1'b1;
                        ready_q  <= ready_en;
                        fsm      <= S_FETCH;
                    end
                end
                S_FETCH: begin
                    if (fetch_xfer) begin
                        sb_r     <= rnd_src;
                        sb_x0    <= sh_s0[7:0];
                        sb_x1    <= sh_s1[7:0];
                        hold_cnt <= '0;
                        ready_q  <= 1'b0;
                        fsm      <= S_HOLD;
                    end
                end
                S_HOLD: begin
                    if (hold_cnt == HOLD_LAST) begin
                        sh_s0 <= nxt_s0;
                        sh_s1 <= nxt_s1;
                        if (byte_cnt == LAST_BYTE) begin
                            // Result and done are registered together so the output is valid with done.
                            state_out_s0 <= nxt_s0;
                            state_out_s1 <= nxt_s1;
                            done         <= 1'b1;
                            busy         <= 1'b0;
                            fsm          <= S_DONE;
                        end else begin
                            byte_cnt <= byte_cnt + 1'b1;
                            ready_q  <= ready_en;
                            fsm      <= S_FETCH;
                        end
                    end else begin
                        hold_cnt <= hold_cnt + 1'b1;
                    end
                end
                S_DONE: begin
                    fsm <= S_IDLE;
                end
                default: begin
                    fsm <= S_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_dom1_sbox_layer_seq.sv
// tb/tb_dom1_sbox_layer_seq.sv - scoreboard bench for dom1_sbox_layer_seq with a behavioural masked S-box
module tb_dom1_sbox_layer_seq;

    logic         clk = 1'b0;
    logic         rst;
    logic         start;
    logic [127:0] in0, in1;
    logic [7:0]   rnd_in;
    logic         rnd_valid;
    logic         rnd_ready;
    logic [7:0]   sb_x0, sb_x1, sb_r, sb_y0, sb_y1;
    logic [127:0] out0, out1;
    logic         busy, done;

    int tests = 0;
    int fails = 0;
    int cyc   = 0;
    int xfers = 0;
    int rdy_cycles = 0;

    typedef struct {
        logic [127:0] res;
        int           due;
        string        name;
    } exp_t;
    exp_t q[$];

    localparam logic [127:0] PAT_IN  = {8'h00, {5{8'hFF, 8'h01, 8'h00}}};
    localparam logic [127:0] PAT_OUT = {8'h65, {5{8'hFF, 8'h4C, 8'h65}}};

    dom1_sbox_layer_seq dut (
        .clk          (clk),
        .rst          (rst),
        .start        (start),
        .state_in_s0  (in0),
        .state_in_s1  (in1),
        .rnd_in       (rnd_in),
        .rnd_valid    (rnd_valid),
        .rnd_ready    (rnd_ready),
        .sb_x0        (sb_x0),
        .sb_x1        (sb_x1),
        .sb_r         (sb_r),
        .sb_y0        (sb_y0),
        .sb_y1        (sb_y1),
        .state_out_s0 (out0),
        .state_out_s1 (out1),
        .busy         (busy),
        .done         (done)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;
    always @(posedge clk) if (rnd_ready && rnd_valid) xfers <= xfers + 1;
    always @(posedge clk) if (rnd_ready) rdy_cycles <= rdy_cycles + 1;

    // SKINNY-128 8-bit S-box, built from its mix/permute round structure.
    function automatic logic [7:0] mix8(input logic [7:0] x);
        return x ^ ((~(((x >> 1) | x) >> 2)) & 8'h11);
    endfunction

    function automatic logic [7:0] perm8(input logic [7:0] x);
        return ((x & 8'h01) << 2) | ((x & 8'h06) << 5) | ((x & 8'h20) >> 5) |
               ((x & 8'hC8) >> 2) | ((x & 8'h10) >> 1);
    endfunction

    function automatic logic [7:0] s8(input logic [7:0] v);
        logic [7:0] x;
        x = v;
        for (int i = 0; i < 3; i++) begin
            x = mix8(x);
            x = perm8(x);
        end
        x = mix8(x);
        return {x[7:3], x[1], x[2], x[0]};
    endfunction

    // Three-stage masked S-box stand-in: output shares are S(x)^r and r.
    logic [7:0] pv0, pv1, pv2, pm0, pm1, pm2;
    always @(posedge clk) begin
        pv0 <= s8(sb_x0 ^ sb_x1) ^ sb_r;
        pm0 <= sb_r;
        pv1 <= pv0;
        pm1 <= pm0;
        pv2 <= pv1;
        pm2 <= pm1;
    end
    assign sb_y0 = pv2;
    assign sb_y1 = pm2;

    always @(negedge clk) rnd_in <= 8'($urandom);

    task automatic check(input string name, input logic [127:0] act, input logic [127:0] req);
        tests++;
        if (act !== req) begin
            fails++;
            $display("FAIL %s: got %h expected %h", name, act, req);
        end
    endtask

    // Monitor: every done pulse is matched against the oldest expected layer.
    always @(negedge clk) begin
        if (done) begin
            if (q.size() == 0) begin
                tests++;
                fails++;
                $display("FAIL unexpected_done: got done at cycle %0d expected none", cyc);
            end else begin
                exp_t e;
                e = q.pop_front();
                check({e.name, "_result"}, out0 ^ out1, e.res);
                check({e.name, "_done_cycle"}, 128'(cyc), 128'(e.due));
            end
        end
    end

    task automatic launch(input logic [127:0] a0, input logic [127:0] a1, input logic push,
                          input logic [127:0] res, input int extra, input string name);
        int st;
        @(negedge clk);
        in0   = a0;
        in1   = a1;
        start = 1'b1;
        st    = cyc + 1;
        if (push) q.push_back('{res: res, due: st + 80 + extra, name: name});
        @(negedge clk);
        start = 1'b0;
    endtask

    task automatic wait_done(input string name);
        logic seen;
        seen = 1'b0;
        for (int i = 0; i < 300 && !seen; i++) begin
            @(negedge clk);
            if (done) seen = 1'b1;
        end
        if (!seen) begin
            tests++;
            fails++;
            $display("FAIL %s_timeout: got no done expected done within 300 cycles", name);
        end
    endtask

    task automatic wait_byte(input int base, input int n, input string name);
        logic hit;
        hit = 1'b0;
        for (int i = 0; i < 200 && !hit; i++) begin
            @(negedge clk);
            if (rnd_ready && (xfers - base) == n) hit = 1'b1;
        end
        if (!hit) begin
            tests++;
            fails++;
            $display("FAIL %s_reach: got no fetch of byte %0d expected one", name, n);
        end
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: got no finish expected finish before time limit");
        $fatal(1, "watchdog");
    end

    initial begin
        int base, rbase;
        logic [7:0] sx0, sx1, sr;
        logic stable;

        rst       = 1'b1;
        start     = 1'b0;
        in0       = '0;
        in1       = '0;
        rnd_valid = 1'b0;
        repeat (3) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        check("reset_busy", 128'(busy), 128'(0));
        check("reset_done", 128'(done), 128'(0));
        check("reset_rnd_ready", 128'(rnd_ready), 128'(0));
        check("reset_out0", out0, 128'h0);
        check("reset_out1", out1, 128'h0);
        check("reset_sb", 128'({sb_x0, sb_x1, sb_r}), 128'(0));

`ifdef DOM1_SEQ_INT_PRNG_EN
        launch('0, '0, 1'b1, {16{8'h65}}, 0, "prng_zero");
        wait_done("prng_zero");
        launch({16{8'h01}} ^ 128'h0f1e2d3c_4b5a6978_8796a5b4_c3d2e1f0, 128'h0f1e2d3c_4b5a6978_8796a5b4_c3d2e1f0,
               1'b1, {16{8'h4C}}, 0, "prng_01");
        repeat (10) @(negedge clk);
        check("prng_busy", 128'(busy), 128'(1));
        check("prng_rnd_ready", 128'(rnd_ready), 128'(0));
        wait_done("prng_01");
`else
        // All-zero state, both shares zero.
        rnd_valid = 1'b1;
        launch('0, '0, 1'b1, {16{8'h65}}, 0, "zero");
        wait_done("zero");

        // All-ones state split with a non-trivial share 0.
        rbase = rdy_cycles;
        launch(128'h01234567_89abcdef_fedcba98_76543210, ~128'h01234567_89abcdef_fedcba98_76543210,
               1'b1, {16{8'hFF}}, 0, "ones");
        repeat (10) @(negedge clk);
        check("ones_busy", 128'(busy), 128'(1));
        check("ones_done_low", 128'(done), 128'(0));
        wait_done("ones");
        check("ones_ready_cycles", 128'(rdy_cycles - rbase), 128'(16));

        // Byte-order pattern with a 7-cycle randomness stall at byte 5.
        base = xfers;
        launch(PAT_IN ^ 128'h5a5a_a5a5_3c3c_c3c3_0f0f_f0f0_9696_6969, 128'h5a5a_a5a5_3c3c_c3c3_0f0f_f0f0_9696_6969,
               1'b1, PAT_OUT, 7, "stall");
        wait_byte(base, 5, "stall");
        rnd_valid = 1'b0;
        sx0 = sb_x0;
        sx1 = sb_x1;
        sr  = sb_r;
        stable = 1'b1;
        repeat (7) begin
            @(negedge clk);
            if (sb_x0 !== sx0 || sb_x1 !== sx1 || sb_r !== sr) stable = 1'b0;
        end
        rnd_valid = 1'b1;
        check("stall_sb_stable", 128'(stable), 128'(1));
        wait_done("stall");

        // Reset 30 cycles into a layer aborts it.
        launch(PAT_IN, '0, 1'b0, '0, 0, "abort");
        repeat (29) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        check("abort_busy", 128'(busy), 128'(0));
        check("abort_done", 128'(done), 128'(0));
        check("abort_out0", out0, 128'h0);
        check("abort_out1", out1, 128'h0);
        launch(PAT_IN, '0, 1'b1, PAT_OUT, 0, "after_abort");
        wait_done("after_abort");

        // start while busy at byte 9 must be ignored.
        base = xfers;
        launch(128'h1111_2222_3333_4444_5555_6666_7777_8888, PAT_IN ^ 128'h1111_2222_3333_4444_5555_6666_7777_8888,
               1'b1, PAT_OUT, 0, "busy_start");
        wait_byte(base, 9, "busy_start");
        in0   = {128{1'b1}};
        in1   = '0;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        wait_done("busy_start");
        repeat (10) @(negedge clk);
        check("busy_start_idle", 128'(busy), 128'(0));
`endif

        repeat (5) @(negedge clk);
        check("scoreboard_empty", 128'(q.size()), 128'(0));
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
